// File: rtl/clock_buffer_pkg.sv
// Shared constants and helpers for the fast-clock input chain.
// Divide range, counter width and divider duty-cycle helper.
`timescale 1ns/100ps
package clock_buffer_pkg;

  localparam int DIVIDE_MIN = 1;
  localparam int DIVIDE_MAX = 8;
  localparam int COUNT_W    = 3;

  typedef logic [COUNT_W-1:0] count_t;

  // Number of ioclk cycles divclk stays high per period.
  // Odd ratios spend the extra cycle high.
  function automatic int high_cycles(input int d);
    return (d + 1) / 2;
  endfunction

endpackage

// File: rtl/diff_clock_divide_buffer_bufio2_divider.sv
// I/O-region divider: word clock and SERDES strobe from ioclk.
// Strobe logic is built only when SERDESSTROBE_EN is defined.
`timescale 1ns/100ps
module bufio2_divider
  import clock_buffer_pkg::*;
#(
  parameter int DIVIDE        = 4,
  parameter bit DIVIDE_BYPASS = 1'b0
) (
  input  logic ioclk,
  input  logic reset,
  output logic divclk,
  output logic serdesstrobe
);

  if (DIVIDE == 1 || DIVIDE_BYPASS) begin : g_pass

    assign divclk       = ioclk & ~reset;
    assign serdesstrobe = 1'b0;

  end else begin : g_div

    localparam count_t LAST = count_t'(DIVIDE - 1);
    localparam count_t HIGH = count_t'(high_cycles(DIVIDE));

    count_t count_q;
    count_t count_next;
    logic   div_q;

    assign count_next = (count_q == LAST) ? '0
                      : count_q + count_t'(1);

    // Counter parks at LAST in reset so the first edge wraps and raises divclk
    always_ff @(posedge ioclk or posedge reset) begin
      if (reset) begin
        count_q <= LAST;
        div_q   <= 1'b0;
      end else begin
        count_q <= count_next;
        div_q   <= (count_next < HIGH);
      end
    end

    assign divclk = div_q;

`ifdef SERDESSTROBE_EN
    logic strobe_q;

    // Strobe covers the ioclk cycle just before each divclk rise
    always_ff @(posedge ioclk or posedge reset) begin
      if (reset) begin
        strobe_q <= 1'b0;
      end else begin
        strobe_q <= (count_next == LAST);
      end
    end

    assign serdesstrobe = strobe_q;
`else
    assign serdesstrobe = 1'b0;
`endif

  end

endmodule

// File: rtl/diff_clock_divide_buffer.sv
// Fast-clock input chain: diff buffer, BUFIO2 divider, BUFG.
// Optional macro SERDESSTROBE_EN enables the SERDES strobe.
`timescale 1ns/100ps
module diff_clock_divide_buffer
  import clock_buffer_pkg::*;
#(
  parameter int DIVIDE        = 4,
  parameter bit I_INVERT      = 1'b0,
  parameter bit DIVIDE_BYPASS = 1'b0
) (
  input  logic clock,
  input  logic clock_b,
  input  logic reset,
  output logic clock_se,
  output logic ioclk,
  output logic divclk,
  output logic serdesstrobe,
  output logic clock_global
);

  if (DIVIDE < DIVIDE_MIN || DIVIDE > DIVIDE_MAX) begin : g_bad_divide
    $fatal(1, "diff_clock_divide_buffer: DIVIDE out of range 1..8");
  end

  logic se_q;

  // Differential receiver keeps its last state while the legs agree
  always_latch begin
    if (clock != clock_b) begin
      se_q <= clock;
    end
  end

  assign clock_se = se_q;
  assign ioclk    = se_q ^ I_INVERT;

  bufio2_divider #(
    .DIVIDE        (DIVIDE),
    .DIVIDE_BYPASS (DIVIDE_BYPASS)
  ) u_div (
    .ioclk        (ioclk),
    .reset        (reset),
    .divclk       (divclk),
    .serdesstrobe (serdesstrobe)
  );

  assign clock_global = divclk;

endmodule

// File: tb/tb_diff_clock_divide_buffer.sv
// Scoreboard bench for diff_clock_divide_buffer.
// Five parameterisations share one differential clock pair.
`timescale 1ns/100ps
module tb_diff_clock_divide_buffer;

  logic clock, clock_b, reset;

  logic se4, io4, dv4, st4, gl4;
  logic se3, io3, dv3, st3, gl3;
  logic se1, io1, dv1, st1, gl1;
  logic sei, ioi, dvi, sti, gli;
  logic seb, iob, dvb, stb, glb;

  diff_clock_divide_buffer #(.DIVIDE(4)) u4 (
    .clock(clock), .clock_b(clock_b), .reset(reset),
    .clock_se(se4), .ioclk(io4), .divclk(dv4),
    .serdesstrobe(st4), .clock_global(gl4));

  diff_clock_divide_buffer #(.DIVIDE(3)) u3 (
    .clock(clock), .clock_b(clock_b), .reset(reset),
    .clock_se(se3), .ioclk(io3), .divclk(dv3),
    .serdesstrobe(st3), .clock_global(gl3));

  diff_clock_divide_buffer #(.DIVIDE(1)) u1 (
    .clock(clock), .clock_b(clock_b), .reset(reset),
    .clock_se(se1), .ioclk(io1), .divclk(dv1),
    .serdesstrobe(st1), .clock_global(gl1));

  diff_clock_divide_buffer #(.DIVIDE(4), .I_INVERT(1'b1)) ui (
    .clock(clock), .clock_b(clock_b), .reset(reset),
    .clock_se(sei), .ioclk(ioi), .divclk(dvi),
    .serdesstrobe(sti), .clock_global(gli));

  diff_clock_divide_buffer #(.DIVIDE(4), .DIVIDE_BYPASS(1'b1)) ub (
    .clock(clock), .clock_b(clock_b), .reset(reset),
    .clock_se(seb), .ioclk(iob), .divclk(dvb),
    .serdesstrobe(stb), .clock_global(glb));

  typedef struct {
    string tag;
    logic  se;
    logic  d4;
    logic  s4;
    logic  d3;
    logic  s3;
    logic  d1;
    logic  di;
    logic  db;
  } exp_t;

  exp_t q[$];
  event ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-derived divider patterns, bit index = ioclk cycle after wrap
  logic [3:0] div4_tab = 4'b0011;
  logic [3:0] stb4_tab = 4'b1000;
  logic [2:0] div3_tab = 3'b011;
  logic [2:0] stb3_tab = 3'b100;

  logic se_m = 1'b0;
  int   n    = 0;
  int   ni   = 0;

  task automatic chk(input string tag, input string name,
                     input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %b want %b at %0t",
               tag, name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per sample event
  initial begin
    forever begin
      @(ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk(e.tag, "clock_se",     se4, e.se);
        chk(e.tag, "ioclk",        io4, e.se);
        chk(e.tag, "div4",         dv4, e.d4);
        chk(e.tag, "glob4",        gl4, e.d4);
        chk(e.tag, "strobe4",      st4, e.s4);
        chk(e.tag, "div3",         dv3, e.d3);
        chk(e.tag, "strobe3",      st3, e.s3);
        chk(e.tag, "div1",         dv1, e.d1);
        chk(e.tag, "glob1",        gl1, e.d1);
        chk(e.tag, "strobe1",      st1, 1'b0);
        chk(e.tag, "ioclk_inv",    ioi, ~e.se);
        chk(e.tag, "div_inv",      dvi, e.di);
        chk(e.tag, "div_byp",      dvb, e.db);
        chk(e.tag, "strobe_byp",   stb, 1'b0);
      end
    end
  end

  task automatic step(input logic c, input logic cb,
                      input logic r, input string tag);
    logic prev;
    exp_t e;
    prev    = se_m;
    clock   = c;
    clock_b = cb;
    reset   = r;
    if (c != cb) se_m = c;
    if (r) begin
      n  = 0;
      ni = 0;
    end else begin
      if (!prev && se_m) n++;
      if (prev && !se_m) ni++;
    end
    #0.5;
    e.tag = tag;
    e.se  = se_m;
    e.d4  = (n == 0) ? 1'b0 : div4_tab[(n - 1) % 4];
    e.d3  = (n == 0) ? 1'b0 : div3_tab[(n - 1) % 3];
`ifdef SERDESSTROBE_EN
    e.s4  = (n == 0) ? 1'b0 : stb4_tab[(n - 1) % 4];
    e.s3  = (n == 0) ? 1'b0 : stb3_tab[(n - 1) % 3];
`else
    e.s4  = 1'b0;
    e.s3  = 1'b0;
`endif
    e.d1  = r ? 1'b0 : se_m;
    e.db  = r ? 1'b0 : se_m;
    e.di  = (ni == 0) ? 1'b0 : div4_tab[(ni - 1) % 4];
    q.push_back(e);
    -> ev;
    #0.5;
  endtask

  task automatic cycles(input int k, input logic r,
                        input string tag);
    for (int i = 0; i < k; i++) begin
      step(1'b1, 1'b0, r, tag);
      step(1'b0, 1'b1, r, tag);
    end
  endtask

  initial begin
    clock   = 1'b0;
    clock_b = 1'b1;
    reset   = 1'b0;
    #1;
    cycles(4, 1'b1, "reset");
    step(1'b0, 1'b1, 1'b0, "release");
    cycles(12, 1'b0, "run");
    step(1'b1, 1'b0, 1'b0, "pre_hold");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, "hold");
    step(1'b0, 1'b1, 1'b0, "resume");
    cycles(4, 1'b0, "resume");
    step(1'b1, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 1'b0, 1'b1, "mid_rst");
    step(1'b0, 1'b1, 1'b1, "mid_rst");
    step(1'b0, 1'b1, 1'b0, "rerelease");
    cycles(6, 1'b0, "rerun");
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
